// File: rtl/magma_arbiter.sv
// Purpose : two-requester round-robin front end for a single block-cipher core; latches the
//           granted job, pulses the core, waits for done or a timeout, returns the result.
// Latency : accept -> m_start next cycle -> rsp valid the cycle after m_done is sampled.
// Backpressure: one job in flight; requesters see ready only in IDLE, the result is held
//           until the owning requester asserts rsp ready.
// Ports   : clk/reset (async, active-low); req0_*/req1_* job inputs with valid/ready;
//           rsp0_*/rsp1_* result handshakes sharing rsp_data/rsp_err; m_* core interface;
//           busy (not IDLE) and owner (index of current or last job).
module magma_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_data,
    input  logic [255:0] req0_key,
    input  logic         req0_rev,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_data,
    input  logic [255:0] req1_key,
    input  logic         req1_rev,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    output logic         m_start,
    output logic [127:0] m_data_in,
    output logic [255:0] m_key,
    input  logic [127:0] m_data_out,
    input  logic         m_done,
    output logic         busy,
    output logic         owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Abort fires on the TIMEOUT-th BUSY cycle (counter starts at 0 on entry).
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           owner_q, owner_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [127:0]   data_in_q, data_in_d;
    logic [255:0]   key_q, key_d;
    logic [127:0]   rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;

    logic           gnt_vld;
    logic           gnt_idx;
    logic [255:0]   sel_key;
    logic           sel_rev;
    logic [255:0]   key_ord;
    logic           rsp_fire;

    // Grant: a lone requester wins; under contention the one not served last wins.
    always_comb begin
        gnt_vld = (state_q == IDLE) && (req0_valid || req1_valid);
        gnt_idx = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    end

    assign req0_ready = gnt_vld && !gnt_idx;
    assign req1_ready = gnt_vld &&  gnt_idx;

    // Decrypt jobs present the key schedule words in reverse order.
    always_comb begin
        sel_key = gnt_idx ? req1_key : req0_key;
        sel_rev = gnt_idx ? req1_rev : req0_rev;
        key_ord = sel_key;
        if (sel_rev) begin
            for (int i = 0; i < 8; i++) begin
                key_ord[32*(7-i) +: 32] = sel_key[32*i +: 32];
            end
        end
    end

    assign rsp_fire = (state_q == RESP) &&
                      ((!owner_q && rsp0_ready) || (owner_q && rsp1_ready));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        data_in_d    = data_in_q;
        key_d        = key_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    data_in_d    = gnt_idx ? req1_data : req0_data;
                    key_d        = key_ord;
                    owner_d      = gnt_idx;
                    last_grant_d = gnt_idx;
                    state_d      = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                // done takes priority over an abort in the same cycle
                if (m_done) begin
                    rsp_data_d = m_data_out;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q == TO_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                if (rsp_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            data_in_q    <= '0;
            key_q        <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            data_in_q    <= data_in_d;
            key_q        <= key_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign m_start    = (state_q == START);
    assign busy       = (state_q != IDLE);
    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) &&  owner_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign m_data_in  = data_in_q;
    assign m_key      = key_q;
    assign owner      = owner_q;

endmodule

// File: tb/tb_magma_arbiter.sv
module tb_magma_arbiter;

    localparam int TO = 8;

    logic         clk;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_data, req1_data;
    logic [255:0] req0_key, req1_key;
    logic         req0_rev, req1_rev;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready, rsp1_ready;
    logic [127:0] rsp_data;
    logic         rsp_err;
    logic         m_start;
    logic [127:0] m_data_in;
    logic [255:0] m_key;
    logic [127:0] m_data_out;
    logic         m_done;
    logic         busy;
    logic         owner;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model state: who was served last (reset value makes req0 win first).
    logic model_last;

    magma_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_key(req0_key), .req0_rev(req0_rev),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_key(req1_key), .req1_rev(req1_rev),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .m_start(m_start), .m_data_in(m_data_in), .m_key(m_key),
        .m_data_out(m_data_out), .m_done(m_done),
        .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rnd256();
        return {rnd128(), rnd128()};
    endfunction

    function automatic logic [255:0] key_model(input logic [255:0] k, input logic r);
        logic [255:0] o;
        o = k;
        if (r) for (int i = 0; i < 8; i++) o[32*(7-i) +: 32] = k[32*i +: 32];
        return o;
    endfunction

    // One complete job. Entered at negedge+1 of an IDLE cycle, returns at negedge+1
    // of the first IDLE cycle after the result is consumed.
    // delay: BUSY cycle index on which m_done is raised (<0 = never). hold: RESP cycles
    // with the owner's rsp ready low.
    task automatic run_job(input logic v0, input logic v1, input int delay, input int hold,
                           input logic r0, input logic r1, input logic fixed_key);
        logic         g;
        logic [127:0] d_exp, res;
        logic [255:0] k_exp, k1;
        logic         err;
        k1 = fixed_key ? {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0} : rnd256();
        req0_valid = v0; req1_valid = v1;
        req0_data = rnd128(); req1_data = rnd128();
        req0_key = rnd256(); req1_key = k1;
        req0_rev = r0; req1_rev = r1;
        #1;
        g = (v0 && v1) ? ~model_last : v1;
        chk("req0_ready_grant", req0_ready, v0 && !g);
        chk("req1_ready_grant", req1_ready, v1 && g);
        chk("busy_idle", busy, 1'b0);
        model_last = g;
        d_exp = g ? req1_data : req0_data;
        k_exp = g ? key_model(req1_key, r1) : key_model(req0_key, r0);

        // START cycle: the granted requester drops, the loser (if any) keeps asking.
        @(negedge clk);
        if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
        req0_data = rnd128(); req1_data = rnd128(); req0_key = rnd256(); req1_key = rnd256();
        #1;
        chk("m_start_start", m_start, 1'b1);
        chk("busy_start", busy, 1'b1);
        chk("m_data_in", m_data_in, d_exp);
        chk("m_key", m_key, k_exp);
        chk("owner", owner, g);
        chk("loser_ready_start", req0_ready | req1_ready, 1'b0);

        res = '0; err = 1'b1;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            m_done = (k == delay);
            m_data_out = rnd128();
            #1;
            chk("m_start_busy", m_start, 1'b0);
            chk("busy_busy", busy, 1'b1);
            chk("rsp_vld_busy", rsp0_valid | rsp1_valid, 1'b0);
            chk("ready_busy", req0_ready | req1_ready, 1'b0);
            if (k == delay) begin
                res = m_data_out; err = 1'b0;
                break;
            end
        end

        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            m_done = 1'b0;
            m_data_out = rnd128();
            if (g) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
            if (h == hold) begin
                if (g) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            #1;
            chk("rsp0_valid", rsp0_valid, !g);
            chk("rsp1_valid", rsp1_valid, g);
            chk("rsp_data", rsp_data, res);
            chk("rsp_err", rsp_err, err);
            chk("busy_resp", busy, 1'b1);
            chk("ready_resp", req0_ready | req1_ready, 1'b0);
        end

        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        chk("busy_after", busy, 1'b0);
        chk("rsp_vld_after", rsp0_valid | rsp1_valid, 1'b0);
        chk("rsp_data_hold", rsp_data, res);
        chk("m_key_hold", m_key, k_exp);
        chk("owner_hold", owner, g);
    endtask

    initial begin
        reset = 1'b0;
        req0_valid = 0; req1_valid = 0; req0_rev = 0; req1_rev = 0;
        req0_data = '0; req1_data = '0; req0_key = '0; req1_key = '0;
        rsp0_ready = 0; rsp1_ready = 0; m_done = 0; m_data_out = '0;
        model_last = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_m_start", m_start, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_data", rsp_data, 128'd0);
        chk("rst_m_key", m_key, 256'd0);
        chk("rst_owner", owner, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;

        // Contended after reset: req0 first (done 3 cycles after start), then req1 back-to-back.
        run_job(1, 1, 2, 0, 0, 0, 0);
        run_job(1, 1, 2, 1, 0, 1, 0);
        // req1 alone, reversed fixed key words.
        run_job(0, 1, 0, 0, 0, 1, 1);
        chk("rev_key_const", m_key, {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7});
        // Timeout abort, then a late m_done in IDLE must be ignored.
        run_job(1, 0, -1, 0, 0, 0, 0);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        #1;
        chk("late_done_busy", busy, 1'b0);
        chk("late_done_rsp", rsp0_valid | rsp1_valid, 1'b0);
        // Done on the final timeout cycle wins.
        run_job(0, 1, TO - 1, 0, 0, 0, 0);
        // Long response stall with req1 contending throughout.
        run_job(1, 1, 1, 20, 0, 0, 0);

        // Randomized jobs.
        for (int j = 0; j < 24; j++) begin
            int v;
            v = $urandom_range(1, 3);
            run_job(v[0], v[1], int'($urandom_range(0, TO + 2)), int'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 0);
        end

        // Reset pulsed mid-BUSY.
        req0_valid = 1'b1; req0_data = rnd128(); req0_key = rnd256();
        repeat (4) @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("pre_rst_busy", busy, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_m_start", m_start, 1'b0);
        chk("midrst_rsp_vld", rsp0_valid | rsp1_valid, 1'b0);
        chk("midrst_rsp_err", rsp_err, 1'b0);
        chk("midrst_m_data_in", m_data_in, 128'd0);
        chk("midrst_m_key", m_key, 256'd0);
        chk("midrst_owner", owner, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        model_last = 1'b1;
        m_done = 1'b1; m_data_out = rnd128();
        @(negedge clk);
        m_done = 1'b0;
        #1;
        chk("postrst_done_ignored", busy, 1'b0);
        chk("postrst_rsp_data", rsp_data, 128'd0);
        run_job(1, 1, 3, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
